// File: rtl/clk_pkg.sv
// Shared constants and types for the time-setting controller and its counter chain.
package clk_pkg;

  localparam logic [1:0] ADDR_SEC  = 2'b00;
  localparam logic [1:0] ADDR_MIN  = 2'b01;
  localparam logic [1:0] ADDR_HRS  = 2'b10;
  localparam logic [1:0] ADDR_NONE = 2'b11;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HRS = 6'd23;

  typedef enum logic [2:0] {
    StRun,
    StSetH,
    StLoadH,
    StSetM,
    StLoadM,
    StSetS,
    StLoadS
  } state_e;

  function automatic logic [5:0] field_max(input logic [1:0] field);
    case (field)
      ADDR_HRS: return MAX_HRS;
      ADDR_MIN: return MAX_MIN;
      default:  return MAX_SEC;
    endcase
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] val, input logic [5:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector (one pulse per press).
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  // Flops reset to "pressed" so a button held through reset never produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clk_set_ctrl.sv
// Push-button time-setting sequencer: edits hours, minutes, seconds in turn and writes
// each committed value onto the shared counter load bus.
module clk_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 30,
  parameter int unsigned TIMEOUT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tc_time_base,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] q_seconds,
  input  logic [5:0] q_minutes,
  input  logic [4:0] q_hours,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_in,
  output logic       edit_active,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT_TICKS - 1);

  state_e               state_q, state_d;
  logic [5:0]           edit_val_q, edit_val_d;
  logic [5:0]           data_in_q, data_in_d;
  logic [1:0]           addrs_q, addrs_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 load_q, load_d;
  logic                 blink_q, blink_d;
  logic                 set_p, up_p, down_p, any_p;
  logic [1:0]           cur_field;
  logic [5:0]           fmax;

  btn_edge u_set  (.clk(clk), .reset(reset), .btn(btn_set),  .pulse(set_p));
  btn_edge u_up   (.clk(clk), .reset(reset), .btn(btn_up),    .pulse(up_p));
  btn_edge u_down (.clk(clk), .reset(reset), .btn(btn_down),  .pulse(down_p));

  assign any_p = set_p | up_p | down_p;

  always_comb begin
    cur_field = ADDR_NONE;
    unique case (state_q)
      StSetH, StLoadH: cur_field = ADDR_HRS;
      StSetM, StLoadM: cur_field = ADDR_MIN;
      StSetS, StLoadS: cur_field = ADDR_SEC;
      default:         cur_field = ADDR_NONE;
    endcase
  end

  assign fmax = field_max(cur_field);

  always_comb begin
    state_d    = state_q;
    edit_val_d = edit_val_q;
    data_in_d  = data_in_q;
    addrs_d    = addrs_q;
    tmo_d      = tmo_q;
    load_d     = 1'b0;
    blink_d    = blink_q;
    unique case (state_q)
      StRun: begin
        tmo_d   = '0;
        blink_d = 1'b0;
        if (set_p) begin
          state_d    = StSetH;
          edit_val_d = clamp({1'b0, q_hours}, MAX_HRS);
        end
      end
      StSetH, StSetM, StSetS: begin
        if (tc_time_base) blink_d = ~blink_q;
        if (any_p) begin
          tmo_d = '0;
          if (set_p) begin
            load_d    = 1'b1;
            addrs_d   = cur_field;
            data_in_d = edit_val_q;
            state_d   = (state_q == StSetH) ? StLoadH :
                        (state_q == StSetM) ? StLoadM : StLoadS;
          end else if (up_p && !down_p) begin
            edit_val_d = (edit_val_q >= fmax) ? 6'd0 : edit_val_q + 6'd1;
          end else if (down_p && !up_p) begin
            edit_val_d = (edit_val_q == 6'd0 || edit_val_q > fmax) ? fmax : edit_val_q - 6'd1;
          end
        end else if (tc_time_base) begin
          if (tmo_q >= TmoLast) begin
            // Abandon the edit; fields committed so far stay in the counters.
            state_d = StRun;
            tmo_d   = '0;
            blink_d = 1'b0;
          end else begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
          end
        end
      end
      StLoadH: begin
        if (tc_time_base) blink_d = ~blink_q;
        state_d    = StSetM;
        edit_val_d = clamp(q_minutes, MAX_MIN);
      end
      StLoadM: begin
        if (tc_time_base) blink_d = ~blink_q;
        state_d    = StSetS;
        edit_val_d = clamp(q_seconds, MAX_SEC);
      end
      StLoadS: begin
        state_d = StRun;
        blink_d = 1'b0;
      end
      default: begin
        state_d = StRun;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      edit_val_q <= '0;
      data_in_q  <= '0;
      addrs_q    <= ADDR_SEC;
      tmo_q      <= '0;
      load_q     <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_val_q <= edit_val_d;
      data_in_q  <= data_in_d;
      addrs_q    <= addrs_d;
      tmo_q      <= tmo_d;
      load_q     <= load_d;
      blink_q    <= blink_d;
    end
  end

  assign load        = load_q;
  assign addrs       = addrs_q;
  assign data_in     = data_in_q;
  assign edit_active = (state_q != StRun);
  assign edit_field  = cur_field;
  assign blink       = blink_q;

endmodule
